// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle, signs applied at commit.
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    input  logic             hi_wen,
    input  logic             lo_wen,
    input  logic [WIDTH-1:0] wdata,
    input  logic             hilo_read,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic             stall_o
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t             state_reg, state_next;
    logic [1:0]         kind_reg;
    logic [CW-1:0]      cnt_reg;
    logic               sign_a_reg, sign_b_reg;
    logic [2*WIDTH-1:0] mcand_reg, prod_reg;
    logic [WIDTH-1:0]   mplier_reg, quot_reg, rem_reg, divisor_reg;
    logic [WIDTH-1:0]   hi_reg, lo_reg;
    logic               done_reg, div_zero_reg;

    logic               accept, commit, dz;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     rem_shift, diff;
    logic [2*WIDTH-1:0] prod_add, prod_fix, result;
    logic [WIDTH-1:0]   q_fix, r_fix, a_orig;

    // op[0] clear selects the signed variant of every operation
    assign a_neg  = ~op[0] & src_a[WIDTH-1];
    assign b_neg  = ~op[0] & src_b[WIDTH-1];
    assign a_mag  = a_neg ? -src_a : src_a;
    assign b_mag  = b_neg ? -src_b : src_b;
    assign accept = (state_reg == S_IDLE) & op_valid & ~flush;
    assign dz     = (divisor_reg == '0);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= S_IDLE;
        else      state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (accept) state_next = (op[2:1] == 2'b01) ? S_DIV : S_MUL;
            S_MUL: begin
                if (flush)                     state_next = S_IDLE;
                else if (cnt_reg == CW'(1))    state_next = S_FIX;
            end
            S_DIV: begin
                if (flush)                     state_next = S_IDLE;
                else if (dz || cnt_reg == CW'(1)) state_next = S_FIX;
            end
            S_FIX:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy    = (state_reg != S_IDLE);
        commit  = (state_reg == S_FIX) & ~flush;
        stall_o = busy & hilo_read;
    end

    // Iteration datapath
    assign prod_add  = prod_reg + (mplier_reg[0] ? mcand_reg : '0);
    assign rem_shift = {rem_reg, quot_reg[WIDTH-1]};
    assign diff      = rem_shift - {1'b0, divisor_reg};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            kind_reg    <= '0;
            cnt_reg     <= '0;
            sign_a_reg  <= 1'b0;
            sign_b_reg  <= 1'b0;
            mcand_reg   <= '0;
            mplier_reg  <= '0;
            prod_reg    <= '0;
            quot_reg    <= '0;
            rem_reg     <= '0;
            divisor_reg <= '0;
        end else if (accept) begin
            kind_reg    <= op[2:1];
            cnt_reg     <= CW'(WIDTH);
            sign_a_reg  <= a_neg;
            sign_b_reg  <= b_neg;
            mcand_reg   <= {{WIDTH{1'b0}}, a_mag};
            mplier_reg  <= b_mag;
            prod_reg    <= '0;
            quot_reg    <= a_mag;
            rem_reg     <= '0;
            divisor_reg <= b_mag;
        end else if (state_reg == S_MUL) begin
            prod_reg   <= prod_add;
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            cnt_reg    <= cnt_reg - CW'(1);
        end else if (state_reg == S_DIV && !dz) begin
            quot_reg <= {quot_reg[WIDTH-2:0], ~diff[WIDTH]};
            rem_reg  <= diff[WIDTH] ? rem_shift[WIDTH-1:0] : diff[WIDTH-1:0];
            cnt_reg  <= cnt_reg - CW'(1);
        end
    end

    // Sign fix-up; a zero divisor leaves the dividend magnitude untouched in quot_reg
    assign prod_fix = (sign_a_reg ^ sign_b_reg) ? -prod_reg : prod_reg;
    assign q_fix    = (sign_a_reg ^ sign_b_reg) ? -quot_reg : quot_reg;
    assign r_fix    = sign_a_reg ? -rem_reg : rem_reg;
    assign a_orig   = sign_a_reg ? -quot_reg : quot_reg;

    always_comb begin
        result = prod_fix;
        case (kind_reg)
            2'b00: result = prod_fix;
            2'b01: result = dz ? {a_orig, {WIDTH{1'b1}}} : {r_fix, q_fix};
            2'b10: result = {hi_reg, lo_reg} + prod_fix;
            2'b11: result = {hi_reg, lo_reg} - prod_fix;
            default: result = prod_fix;
        endcase
    end

    // Architectural HI/LO; a commit on the same edge wins over MTHI/MTLO
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_reg       <= '0;
            lo_reg       <= '0;
            done_reg     <= 1'b0;
            div_zero_reg <= 1'b0;
        end else begin
            if (commit) begin
                hi_reg <= result[2*WIDTH-1:WIDTH];
                lo_reg <= result[WIDTH-1:0];
            end else begin
                if (hi_wen) hi_reg <= wdata;
                if (lo_wen) lo_reg <= wdata;
            end
            done_reg     <= commit;
            div_zero_reg <= commit & (kind_reg == 2'b01) & dz;
        end
    end

    assign hi       = hi_reg;
    assign lo       = lo_reg;
    assign done     = done_reg;
    assign div_zero = div_zero_reg;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter at WIDTH=32: multiply, divide, accumulate,
// flush, reset abort, stall generation and back-to-back issue.
module tb_mdu_iter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         op_valid = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] src_a = '0, src_b = '0;
    logic         flush = 1'b0, hi_wen = 1'b0, lo_wen = 1'b0;
    logic [W-1:0] wdata = '0;
    logic         hilo_read = 1'b0;
    logic [W-1:0] hi, lo;
    logic         busy, done, div_zero, stall_o;

    int total = 0;
    int passed = 0;

    mdu_iter #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op(op),
        .src_a(src_a), .src_b(src_b), .flush(flush),
        .hi_wen(hi_wen), .lo_wen(lo_wen), .wdata(wdata),
        .hilo_read(hilo_read), .hi(hi), .lo(lo), .busy(busy),
        .done(done), .div_zero(div_zero), .stall_o(stall_o)
    );

    always #5 clk = ~clk;

    // Called at a negedge; the op is accepted on the following posedge.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        op_valid = 1'b1; op = o; src_a = a; src_b = b;
        @(negedge clk);
        op_valid = 1'b0;
    endtask

    // Returns the number of posedges after the accept edge until done is seen.
    task automatic wait_done(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!done && cycles < 100);
        $display("txn op=%0d a=%h b=%h cycles=%0d hi=%h lo=%h dz=%0b", op, src_a, src_b, cycles, hi, lo, div_zero);
    endtask

    task automatic mtx(input logic hw, input logic lw, input logic [W-1:0] d);
        hi_wen = hw; lo_wen = lw; wdata = d;
        @(negedge clk);
        hi_wen = 1'b0; lo_wen = 1'b0;
    endtask

    task automatic test_reset;
        #12;
        total++; if ({hi, lo} !== '0) $display("FAIL reset_hilo got %h want 0", {hi, lo}); else passed++;
        total++; if ({busy, done, div_zero, stall_o} !== 4'b0) $display("FAIL reset_flags got %b want 0000", {busy, done, div_zero, stall_o}); else passed++;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mult;
        int c;
        issue(3'b000, 32'hFFFFFFFD, 32'd5);
        total++; if (busy !== 1'b1) $display("FAIL mult_busy got %b want 1", busy); else passed++;
        wait_done(c);
        total++; if (c !== W + 1) $display("FAIL mult_latency got %0d want %0d", c, W + 1); else passed++;
        total++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFF1) $display("FAIL mult_hilo got %h want FFFFFFFFFFFFFFF1", {hi, lo}); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL mult_busy_done got %b want 0", busy); else passed++;
        @(negedge clk);
        total++; if (done !== 1'b0) $display("FAIL mult_done_pulse got %b want 0", done); else passed++;
        issue(3'b001, 32'hFFFFFFFD, 32'd5);
        wait_done(c);
        total++; if ({hi, lo} !== 64'h00000004_FFFFFFF1) $display("FAIL multu_hilo got %h want 00000004FFFFFFF1", {hi, lo}); else passed++;
    endtask

    task automatic test_div;
        int c;
        issue(3'b011, 32'd100, 32'd7);
        wait_done(c);
        total++; if ({hi, lo} !== {32'd2, 32'd14}) $display("FAIL divu_hilo got %h want %h", {hi, lo}, {32'd2, 32'd14}); else passed++;
        total++; if (div_zero !== 1'b0) $display("FAIL divu_dz got %b want 0", div_zero); else passed++;
        total++; if (c !== W + 1) $display("FAIL divu_latency got %0d want %0d", c, W + 1); else passed++;
        issue(3'b010, 32'hFFFFFFF9, 32'd2);
        wait_done(c);
        total++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFD) $display("FAIL div_neg got %h want FFFFFFFFFFFFFFFD", {hi, lo}); else passed++;
        issue(3'b010, 32'h80000000, 32'hFFFFFFFF);
        wait_done(c);
        total++; if ({hi, lo} !== 64'h00000000_80000000) $display("FAIL div_ovf got %h want 0000000080000000", {hi, lo}); else passed++;
    endtask

    task automatic test_div_zero;
        int c;
        issue(3'b011, 32'd9, 32'd0);
        wait_done(c);
        total++; if (c !== 2) $display("FAIL dz_latency got %0d want 2", c); else passed++;
        total++; if (div_zero !== 1'b1) $display("FAIL dz_flag got %b want 1", div_zero); else passed++;
        total++; if ({hi, lo} !== {32'd9, 32'hFFFFFFFF}) $display("FAIL dz_hilo got %h want 00000009FFFFFFFF", {hi, lo}); else passed++;
        @(negedge clk);
        total++; if ({done, div_zero} !== 2'b00) $display("FAIL dz_pulse got %b want 00", {done, div_zero}); else passed++;
    endtask

    task automatic test_madd_msub;
        int c;
        mtx(1'b1, 1'b0, 32'd0);
        mtx(1'b0, 1'b1, 32'd10);
        total++; if ({hi, lo} !== {32'd0, 32'd10}) $display("FAIL mtx_hilo got %h want 000000000000000A", {hi, lo}); else passed++;
        issue(3'b100, 32'd3, 32'd4);
        wait_done(c);
        total++; if ({hi, lo} !== {32'd0, 32'd22}) $display("FAIL madd_hilo got %h want 0000000000000016", {hi, lo}); else passed++;
        issue(3'b111, 32'd5, 32'd5);
        wait_done(c);
        total++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFD) $display("FAIL msubu_hilo got %h want FFFFFFFFFFFFFFFD", {hi, lo}); else passed++;
    endtask

    task automatic test_flush;
        int pulses = 0;
        issue(3'b000, 32'd3, 32'd4);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        total++; if (busy !== 1'b0) $display("FAIL flush_busy got %b want 0", busy); else passed++;
        for (int i = 0; i < 40; i++) begin
            if (done || div_zero) pulses++;
            @(negedge clk);
        end
        $display("txn flush hi=%h lo=%h pulses=%0d", hi, lo, pulses);
        total++; if (pulses !== 0) $display("FAIL flush_done got %0d pulses want 0", pulses); else passed++;
        total++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFD) $display("FAIL flush_hilo got %h want FFFFFFFFFFFFFFFD", {hi, lo}); else passed++;
    endtask

    task automatic test_rst_abort;
        issue(3'b000, 32'd3, 32'd4);
        repeat (9) @(negedge clk);
        rst = 1'b0;
        #1;
        $display("txn rst_abort hi=%h lo=%h busy=%0b done=%0b", hi, lo, busy, done);
        total++; if ({hi, lo} !== '0) $display("FAIL rst_abort_hilo got %h want 0", {hi, lo}); else passed++;
        total++; if ({busy, done, div_zero} !== 3'b0) $display("FAIL rst_abort_flags got %b want 000", {busy, done, div_zero}); else passed++;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_stall_mtlo;
        int stall_bad = 0;
        int busy_cycles = 0;
        hilo_read = 1'b1;
        total++; if (stall_o !== 1'b0) $display("FAIL stall_idle got %b want 0", stall_o); else passed++;
        issue(3'b000, 32'd3, 32'd7);
        for (int k = 0; k < 60 && !done; k++) begin
            if (busy) busy_cycles++;
            if (busy && stall_o !== 1'b1) stall_bad++;
            if (k == 5) begin
                total++; if (lo !== 32'h55) $display("FAIL mtlo_mid got %h want 00000055", lo); else passed++;
            end
            lo_wen = (k == 4); wdata = 32'h55;
            @(negedge clk);
        end
        lo_wen = 1'b0;
        $display("txn stall hi=%h lo=%h busy_cycles=%0d", hi, lo, busy_cycles);
        total++; if (stall_bad !== 0 || busy_cycles !== W + 1) $display("FAIL stall_busy got bad=%0d cycles=%0d want 0 and %0d", stall_bad, busy_cycles, W + 1); else passed++;
        total++; if ({done, stall_o} !== 2'b10) $display("FAIL stall_done got %b want 10", {done, stall_o}); else passed++;
        total++; if ({hi, lo} !== {32'd0, 32'd21}) $display("FAIL mtlo_commit got %h want 0000000000000015", {hi, lo}); else passed++;
        hilo_read = 1'b0;
    endtask

    task automatic test_back_to_back;
        int c;
        issue(3'b001, 32'd6, 32'd7);
        wait_done(c);
        total++; if (lo !== 32'd42) $display("FAIL b2b_first got %h want 0000002A", lo); else passed++;
        issue(3'b011, 32'd50, 32'd5);
        total++; if (busy !== 1'b1) $display("FAIL b2b_accept got %b want 1", busy); else passed++;
        // A request while busy must be ignored
        issue(3'b000, 32'd9, 32'd9);
        wait_done(c);
        total++; if (c !== W) $display("FAIL b2b_latency got %0d want %0d", c, W); else passed++;
        total++; if ({hi, lo} !== {32'd0, 32'd10}) $display("FAIL b2b_second got %h want 000000000000000A", {hi, lo}); else passed++;
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0) $display("FAIL b2b_ignored got busy=%b want 0", busy); else passed++;
    endtask

    initial begin
        test_reset;
        test_mult;
        test_div;
        test_div_zero;
        test_madd_msub;
        test_flush;
        test_rst_abort;
        test_stall_mtlo;
        test_back_to_back;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
